// File: rtl/csa_pkg.sv
// Shared sizing helpers for the carry-save accumulation tree.
// Row counts per 3:2 level, number of levels and result width.
package csa_pkg;

  // Rows remaining after lvl levels of 3:2 compression starting from n rows.
  function automatic int unsigned csa_rows(input int unsigned n, input int unsigned lvl);
    int unsigned r;
    r = n;
    for (int unsigned i = 0; i < lvl; i++) begin
      r = 2 * (r / 3) + (r % 3);
    end
    return r;
  endfunction

  function automatic int unsigned csa_levels(input int unsigned n);
    int unsigned r;
    int unsigned l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      l++;
    end
    return l;
  endfunction

  function automatic int unsigned csa_ow(input int unsigned n, input int unsigned w,
                                         input int unsigned acc_bits);
    return w + int'($clog2(n)) + acc_bits;
  endfunction

endpackage

// File: rtl/csa_accum_tree_if.sv
// Beat input / packet result bundle for csa_accum_tree.
interface csa_accum_tree_if #(
  parameter int unsigned N  = 5,
  parameter int unsigned W  = 4,
  parameter int unsigned OW = 15
);
  logic          in_valid;
  logic          in_last;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic [OW-1:0] out_sum;
  logic          out_ovf;

  modport master (
    output in_valid, in_last, in_data,
    input  out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_last, in_data,
    output out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/csa_3to2.sv
// Combinational 3:2 carry-save compressor; carry is pre-shifted by one
// position and truncated so both outputs share the input width.
module csa_3to2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);
  logic [WIDTH-1:0] maj;

  always_comb begin
    maj   = (a & b) | (a & c) | (b & c);
    sum   = a ^ b ^ c;
    carry = WIDTH'({maj, 1'b0});
  end
endmodule

// File: rtl/csa_accum_tree.sv
// Pipelined N-operand carry-save reduction tree with a final CPA that
// accumulates beat sums into a packet result closed by in_last.
module csa_accum_tree
  import csa_pkg::*;
#(
  parameter int unsigned N        = 5,
  parameter int unsigned W        = 4,
  parameter int unsigned SIGNED   = 0,
  parameter int unsigned ACC_BITS = 8
) (
  input logic             clk,
  input logic             rst,
  csa_accum_tree_if.slave bus
);
  localparam int unsigned OW = csa_ow(N, W, ACC_BITS);
  localparam int unsigned L  = csa_levels(N);
  localparam int unsigned NR = (N < 2) ? 2 : N;
  localparam int unsigned CW = ACC_BITS + 1;
  localparam logic [CW-1:0] CNT_LIM = CW'(1) << ACC_BITS;
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Level 0 holds the extended operands; level k holds the rows after k 3:2 stages.
  logic [OW-1:0] rows_d [L+1][NR];
  logic [OW-1:0] rows_q [L+1][NR];
  logic [L:0]    valid_q;
  logic [L:0]    last_q;

  logic [OW-1:0] acc_q;
  logic [OW-1:0] cpa;
  logic [OW-1:0] acc_nxt;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic          first_q;

  for (genvar k = 0; k < NR; k++) begin : g_ext
    if (k < N) begin : g_op
      logic [W-1:0] op;
      assign op = bus.in_data[k*W +: W];
      if (SIGNED != 0) begin : g_sext
        assign rows_d[0][k] = OW'($signed(op));
      end else begin : g_zext
        assign rows_d[0][k] = OW'(op);
      end
    end else begin : g_pad
      assign rows_d[0][k] = '0;
    end
  end

  // Each level compresses full triples and forwards the leftover rows unchanged.
  for (genvar lv = 1; lv <= L; lv++) begin : g_lvl
    localparam int unsigned RIN = csa_rows(N, lv - 1);
    localparam int unsigned G   = RIN / 3;
    localparam int unsigned REM = RIN % 3;

    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_3to2 #(.WIDTH(OW)) u_csa (
        .a    (rows_q[lv-1][3*g]),
        .b    (rows_q[lv-1][3*g+1]),
        .c    (rows_q[lv-1][3*g+2]),
        .sum  (rows_d[lv][2*g]),
        .carry(rows_d[lv][2*g+1])
      );
    end

    for (genvar k = 2 * G; k < NR; k++) begin : g_fill
      if (k < 2 * G + REM) begin : g_pass
        assign rows_d[lv][k] = rows_q[lv-1][k+G];
      end else begin : g_zero
        assign rows_d[lv][k] = '0;
      end
    end
  end

  // A packet's first beat loads the accumulator instead of adding to it.
  always_comb begin
    cpa     = rows_q[L][0] + rows_q[L][1];
    acc_nxt = cpa;
    cnt_nxt = CW'(1);
    if (!first_q) begin
      acc_nxt = acc_q + cpa;
      cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q        <= '{default: '0};
      valid_q       <= '0;
      last_q        <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      first_q       <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      rows_q     <= rows_d;
      valid_q[0] <= bus.in_valid;
      last_q[0]  <= bus.in_valid & bus.in_last;
      for (int unsigned i = 1; i <= L; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end

      bus.out_valid <= valid_q[L] & last_q[L];
      // Bubbles leave accumulator, counter and packet-start flag untouched.
      if (valid_q[L]) begin
        acc_q   <= acc_nxt;
        cnt_q   <= cnt_nxt;
        first_q <= last_q[L];
        if (last_q[L]) begin
          bus.out_sum <= acc_nxt;
          bus.out_ovf <= (cnt_nxt > CNT_LIM);
        end
      end
    end
  end

endmodule

// File: tb/tb_csa_accum_tree.sv
// Self-checking bench for csa_accum_tree: directed packets on three
// configurations plus random traffic against a packet-sum reference model.
module tb_csa_accum_tree;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  csa_accum_tree_if #(.N(5), .W(4), .OW(15)) b0 ();
  csa_accum_tree_if #(.N(5), .W(4), .OW(15)) b1 ();
  csa_accum_tree_if #(.N(5), .W(4), .OW(9))  b2 ();

  csa_accum_tree #(.N(5), .W(4), .SIGNED(0), .ACC_BITS(8)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  csa_accum_tree #(.N(5), .W(4), .SIGNED(1), .ACC_BITS(8)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  csa_accum_tree #(.N(5), .W(4), .SIGNED(0), .ACC_BITS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic [63:0] sum;
    logic        ovf;
    int          at_edge;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            mon_e;
  longint unsigned pk_sum = 0;
  int unsigned     pk_cnt = 0;
  int              n_checks = 0;
  int              n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    b0.in_valid = 1'b0; b0.in_last = 1'b0; b0.in_data = '0;
    b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.in_data = '0;
    b2.in_valid = 1'b0; b2.in_last = 1'b0; b2.in_data = '0;
  endtask

  // Reference: unsigned packet sum modulo 2^15, overflow when more than 256 beats.
  task automatic model_beat(input bit l, input logic [19:0] d);
    exp_t e;
    for (int i = 0; i < 5; i++) pk_sum += 64'(d[i*4 +: 4]);
    pk_cnt++;
    if (l) begin
      e.sum     = 64'(pk_sum % 64'd32768);
      e.ovf     = (pk_cnt > 256);
      e.at_edge = edge_cnt + 5;
      exp_q.push_back(e);
      pk_sum = 0;
      pk_cnt = 0;
    end
  endtask

  task automatic beat(input int id, input bit v, input bit l, input logic [19:0] d);
    @(posedge clk); #1;
    set_idle();
    case (id)
      0:       begin b0.in_valid = v; b0.in_last = l; b0.in_data = d; end
      1:       begin b1.in_valid = v; b1.in_last = l; b1.in_data = d; end
      default: begin b2.in_valid = v; b2.in_last = l; b2.in_data = d; end
    endcase
    if (id == 0 && v) model_beat(l, d);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic wait_out(input int id, input logic [63:0] es, input logic eo, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (id == 1 && b1.out_valid === 1'b1) begin
        seen = 1'b1;
        check({tag, "_sum"}, 64'(b1.out_sum), es);
        check({tag, "_ovf"}, 64'(b1.out_ovf), 64'(eo));
      end else if (id == 2 && b2.out_valid === 1'b1) begin
        seen = 1'b1;
        check({tag, "_sum"}, 64'(b2.out_sum), es);
        check({tag, "_ovf"}, 64'(b2.out_ovf), 64'(eo));
      end
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
  endtask

  // Scoreboard for the unsigned instance: value, overflow and exact arrival edge.
  always @(negedge clk) begin
    if (b0.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("d0_spurious_valid", 64'(b0.out_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("d0_sum", 64'(b0.out_sum), mon_e.sum);
        check("d0_ovf", 64'(b0.out_ovf), 64'(mon_e.ovf));
        check("d0_latency_edge", 64'(edge_cnt), 64'(mon_e.at_edge));
      end
    end
  end

  initial begin
    logic [19:0] d;
    bit v;
    bit l;
    set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_d0_valid", 64'(b0.out_valid), 64'd0);
    check("rst_d0_sum",   64'(b0.out_sum),   64'd0);
    check("rst_d0_ovf",   64'(b0.out_ovf),   64'd0);
    check("rst_d1_valid", 64'(b1.out_valid), 64'd0);
    check("rst_d1_sum",   64'(b1.out_sum),   64'd0);
    check("rst_d2_valid", 64'(b2.out_valid), 64'd0);
    check("rst_d2_sum",   64'(b2.out_sum),   64'd0);
    check("rst_d2_ovf",   64'(b2.out_ovf),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All operands 15, single beat: 75.
    beat(0, 1'b1, 1'b1, 20'hFFFFF);
    repeat (6) idle();
    // Three beats of {1,2,3,4,5} with a bubble: 45.
    beat(0, 1'b1, 1'b0, 20'h54321);
    beat(0, 1'b0, 1'b0, 20'h00000);
    beat(0, 1'b1, 1'b0, 20'h54321);
    beat(0, 1'b1, 1'b1, 20'h54321);
    repeat (6) idle();
    // Back-to-back single-beat packets: 5 then 10 on consecutive cycles.
    beat(0, 1'b1, 1'b1, 20'h11111);
    beat(0, 1'b1, 1'b1, 20'h22222);
    repeat (8) idle();

    // Reset with a closed packet and a partial packet in flight.
    beat(0, 1'b1, 1'b0, 20'h77777);
    beat(0, 1'b1, 1'b1, 20'h99999);
    beat(0, 1'b1, 1'b0, 20'h55555);
    @(posedge clk); #1;
    set_idle();
    rst = 1'b1;
    exp_q.delete();
    pk_sum = 0;
    pk_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    beat(0, 1'b1, 1'b1, 20'h00003);
    repeat (8) idle();

    // Signed instance: five -8 operands and five +7 operands.
    beat(1, 1'b1, 1'b1, 20'h88888);
    idle();
    wait_out(1, 64'h7FD8, 1'b0, "signed_neg");
    beat(1, 1'b1, 1'b1, 20'h77777);
    idle();
    wait_out(1, 64'd35, 1'b0, "signed_pos");

    // ACC_BITS=2 instance: five beats overflow, four do not.
    for (int i = 0; i < 5; i++) beat(2, 1'b1, (i == 4), 20'h11111);
    idle();
    wait_out(2, 64'd25, 1'b1, "acc_ovf5");
    for (int i = 0; i < 4; i++) beat(2, 1'b1, (i == 3), 20'h11111);
    idle();
    wait_out(2, 64'd20, 1'b0, "acc_ok4");

    // Random traffic with bubbles and random packet boundaries.
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(4) != 0);
      l = ($urandom_range(3) == 0);
      d = 20'($urandom);
      if (i == 999) begin
        v = 1'b1;
        l = 1'b1;
      end
      beat(0, v, l, d);
    end
    repeat (10) idle();
    check("d0_pending_results", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/csa_accum_tree.md
# csa_accum_tree

Pipelined, parametrised multi-operand adder for the CNN datapath. Each valid beat carries N operands of W bits; they are reduced through a registered tree of 3:2 carry-save compressors and a final carry-propagate adder. The result is accumulated across beats until a `last`-flagged beat closes the packet. It sits behind the multiplier array as the partial-product / channel-sum reducer, succeeding the single-cycle combinational carry-save adder.

## Interface
Parameters:
- N, 5 — operands per beat (≥1)
- W, 4 — operand width in bits
- SIGNED, 0 — 1: operands two's-complement, sign-extended; 0: zero-extended
- ACC_BITS, 8 — accumulation headroom; a packet may hold up to 2^ACC_BITS beats
- OW (derived, localparam) = W + clog2(N) + ACC_BITS — result width (N=5, W=4 → 15)
- L (derived, localparam) — number of 3:2 levels needed to reduce N rows to 2 (N≤2 → 0; N=5 → 3)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  beat present this cycle
- in_last  in  1  beat closes the packet; ignored when in_valid=0
- in_data  in  N*W  operand i = in_data[i*W +: W]
- out_valid  out  1  one-cycle pulse: packet result on out_sum
- out_sum  out  OW  packet sum (two's-complement if SIGNED)
- out_ovf  out  1  packet exceeded 2^ACC_BITS beats; valid with out_valid

## Operation
- No backpressure: one beat accepted every cycle in_valid=1; the pipeline never stalls.
- Operands are extended to OW bits per SIGNED, then reduced row-wise: each level groups rows in threes (3→2), and leftover rows pass through. Rows per level: r' = 2·floor(r/3) + (r mod 3).
- Final stage: CPA of the two rows plus the accumulator. If the beat is the first of its packet, the accumulator is loaded with the CPA sum, not added to.
- A beat is the first of its packet if it is the first beat after reset or the previous accepted beat had in_last=1.
- valid and last travel alongside the data in a shift chain. Bubbles (in_valid=0) leave the accumulator untouched and may appear mid-packet.
- Beat counter: ACC_BITS+1 bits, loaded with 1 on the first beat and incremented on each later beat, saturating. out_ovf=1 if count > 2^ACC_BITS at the last beat. out_sum is then the modulo-2^OW value.
- Within the budget, out_sum equals the exact arithmetic sum of all operands in the packet.

## Timing
- Latency: a last beat sampled at edge t gives out_valid=1 in the cycle after edge t+L+1, i.e. L+2 edges (N=5: 5 edges).
- Pipeline stages: input register, L CSA registers, CPA/accumulator register.
- Throughput: 1 beat/cycle. Single-beat packets back to back give out_valid on consecutive cycles.
- A last beat followed immediately by the next packet's first beat must not leak the old sum into the new packet.
- Reset values: out_valid=0, out_sum=0, out_ovf=0, accumulator=0, counter=0, all pipeline valid bits=0.
- Reset mid-operation discards all in-flight beats and any partial packet. The first valid beat after rst deasserts starts a new packet.

## Structure
- Package csa_pkg holds:
  - function csa_levels(n) returning L
  - function csa_rows(n, lvl) giving the row count at each level
  - function csa_ow(n, w, acc_bits)
- Sub-module csa_3to2: generic-width combinational 3:2 compressor, parameter WIDTH, outputs sum and carry (carry shifted left by 1, truncated to WIDTH).
- The top is a generate loop over levels instantiating csa_3to2 per row triple, with registered outputs per level.

## Test plan
- N=5, W=4, SIGNED=0: one beat of all operands 15 with last=1 → out_sum=75, out_valid 5 edges after input, out_ovf=0.
- Three beats of {1,2,3,4,5}, last on the third, with one bubble between beats 1 and 2 → single out_valid, out_sum=45.
- Back-to-back single-beat packets {1,1,1,1,1} then {2,2,2,2,2} → out_valid on consecutive cycles with 5 then 10 (no carry-over).
- SIGNED=1: all operands 4'b1000 (−8), one beat → out_sum=−40 (15'h7FD8); all 4'b0111 → 35.
- ACC_BITS=2: five beats of all-1 operands, last on the fifth → out_ovf=1. Four beats → out_ovf=0, out_sum=20.
- Assert rst for one cycle while a packet is in flight → no out_valid for it; the next packet {3,0,0,0,0} gives 3. Then run 1000 LFSR-driven random beats with random last, compared against a behavioural sum; zero mismatches required.
